tt_sweep_ctrl: RTL and testbench

- Sequential stimulus/response controller that sits directly around the 3-input combinational stage (A, B, C -> E).
- Upstream, it drives A, B, C through all 8 input combinations in binary order. Downstream, it samples E for each combination.
- It assembles an 8-bit truth table and compares it against an expected table.
- Replaces hand-written delay/display sequences with a synthesizable, self-checking sweep.

---
 rtl/tt_sweep_pkg.sv | 32 +++
 rtl/tt_sweep_ctrl_timer.sv | 41 ++++
 rtl/tt_sweep_ctrl.sv | 130 +++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
//   sweep_state_t : controller state encoding
//   NUM_COMBOS    : number of input combinations of the 3-input stage
//   IDX_W         : width of the combination index
//   EXP_OR_AND    : truth table of E = (A|B)&C, bit i = E for {A,B,C} = i
//   first_set()   : lowest set bit of a table-wide vector, 0 if none
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int NUM_COMBOS = 8;
    localparam int IDX_W      = 3;

    localparam logic [NUM_COMBOS-1:0] EXP_OR_AND = 8'hA8;

    // LSB-first priority encoder; scanning downward lets the lowest hit win.
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_COMBOS-1:0] vec);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = NUM_COMBOS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                pos = IDX_W'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl_timer.sv
// Hold timer: counts the cycles a stimulus combination has been presented.
// Ports:
//   Clock      : system clock, rising edge
//   Reset      : asynchronous, active-high
//   clear      : restart the count at 0 (sweep start)
//   enable     : advance the count (while driving stimulus)
//   last_cycle : high on the final cycle of the hold window
module tt_hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic last_cycle
);

    localparam int CNT_W_RAW = $clog2(HOLD_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign last_cycle = (cnt == CNT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            // Wrapping at the last cycle starts the next combination's window.
            if (last_cycle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller around a 3-input combinational stage.
// Drives {A,B,C} through 0..7, holds each combination HOLD_CYCLES cycles,
// samples E on the last cycle and compares the assembled table to EXPECTED.
// Ports:
//   Clock, Reset : clock (rising edge) and asynchronous active-high reset
//   start        : request a sweep (ignored while a sweep is running)
//   E            : response of the stage under test
//   A, B, C      : registered stimulus, {A,B,C} = combination index
//   busy         : sweep in progress
//   done         : sweep finished; held until next start or Reset
//   table_out    : captured truth table, bit i = E for {A,B,C} = i
//   pass         : table_out == EXPECTED (valid with done)
//   first_fail   : lowest mismatching index (valid with done && !pass)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no sweep since reset; waiting for start
// DRIVE | presenting combination idx and waiting for its sample edge
// DONE  | table, pass and first_fail held; start launches a new sweep
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int                    HOLD_CYCLES = 2,
    parameter logic [NUM_COMBOS-1:0] EXPECTED    = EXP_OR_AND
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  E,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_COMBOS-1:0] table_out,
    output logic                  pass,
    output logic [IDX_W-1:0]      first_fail
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COMBOS - 1);

    sweep_state_t          state_q;
    sweep_state_t          state_d;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      stim;
    logic                  last_cycle;
    logic                  start_acc;
    logic                  capture;
    logic [NUM_COMBOS-1:0] table_final;

    assign start_acc = start && (state_q != DRIVE);
    assign capture   = (state_q == DRIVE) && last_cycle;

    assign {A, B, C} = stim;

    tt_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (start_acc),
        .enable     (state_q == DRIVE),
        .last_cycle (last_cycle)
    );

    // Table including the bit being captured this edge, so the final
    // compare sees all eight samples.
    always_comb begin
        table_final      = table_out;
        table_final[idx] = E;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (capture && (idx == IDX_LAST)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx        <= '0;
            stim       <= '0;
            table_out  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            first_fail <= '0;
        end else if (start_acc) begin
            idx        <= '0;
            stim       <= '0;
            table_out  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            first_fail <= '0;
        end else if (capture) begin
            table_out <= table_final;
            if (idx == IDX_LAST) begin
                busy       <= 1'b0;
                done       <= 1'b1;
                pass       <= (table_final == EXPECTED);
                // A matching table has no set bit, so this yields 0 on pass.
                first_fail <= first_set(table_final ^ EXPECTED);
            end else begin
                idx  <= idx + IDX_W'(1);
                stim <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;
    import tt_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       e0, e1, e1_q;
    logic       a0, b0, c0, busy0, done0, pass0;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] tbl0, tbl1;
    logic [2:0] ff0, ff1;
    int         mode0 = 0;
    int         mode1 = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // Stage models: 0 (A|B)&C, 1 A|B, 2 tie 0, 3 tie 1, 4 A^B^C, 5 A&B&C
    function automatic logic stage(input int mode, input logic a, input logic b, input logic c);
        case (mode)
            0: return (a | b) & c;
            1: return a | b;
            2: return 1'b0;
            3: return 1'b1;
            4: return a ^ b ^ c;
            5: return a & b & c;
            default: return 1'b0;
        endcase
    endfunction

    always_comb e0 = stage(mode0, a0, b0, c0);

    // Registered stage for the HOLD_CYCLES=1 instance; mode1=1 ties E low.
    always @(negedge clk) e1_q <= stage(0, a1, b1, c1);
    assign e1 = (mode1 == 1) ? 1'b0 : e1_q;

    tt_sweep_ctrl #(.HOLD_CYCLES(2), .EXPECTED(8'hA8)) dut0 (
        .Clock(clk), .Reset(rst), .start(start0), .E(e0),
        .A(a0), .B(b0), .C(c0), .busy(busy0), .done(done0),
        .table_out(tbl0), .pass(pass0), .first_fail(ff0)
    );

    tt_sweep_ctrl #(.HOLD_CYCLES(1), .EXPECTED(8'hA8)) dut1 (
        .Clock(clk), .Reset(rst), .start(start1), .E(e1),
        .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1),
        .table_out(tbl1), .pass(pass1), .first_fail(ff1)
    );

    typedef struct {
        int         mode;
        logic [7:0] tbl;
        logic       pas;
        logic [2:0] ff;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " abc"}, {a0, b0, c0}, 0);
        chk({tag, " busy"}, busy0, 0);
        chk({tag, " done"}, done0, 0);
        chk({tag, " table"}, tbl0, 0);
        chk({tag, " pass"}, pass0, 0);
        chk({tag, " first_fail"}, ff0, 0);
    endtask

    task automatic check_result0(input string tag, input logic [7:0] t, input logic p, input logic [2:0] f);
        chk({tag, " done"}, done0, 1);
        chk({tag, " busy"}, busy0, 0);
        chk({tag, " table"}, tbl0, t);
        chk({tag, " pass"}, pass0, p);
        chk({tag, " first_fail"}, ff0, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad;

        vecs[0] = '{mode: 0, tbl: 8'hA8, pas: 1'b1, ff: 3'd0};
        vecs[1] = '{mode: 1, tbl: 8'hFC, pas: 1'b0, ff: 3'd2};
        vecs[2] = '{mode: 2, tbl: 8'h00, pas: 1'b0, ff: 3'd3};
        vecs[3] = '{mode: 3, tbl: 8'hFF, pas: 1'b0, ff: 3'd0};
        vecs[4] = '{mode: 4, tbl: 8'h96, pas: 1'b0, ff: 3'd1};
        vecs[5] = '{mode: 5, tbl: 8'h80, pas: 1'b0, ff: 3'd3};

        // Reset is applied before any clock edge.
        #1;
        check_all_zero("reset");
        chk("reset dut1 done", done1, 0);
        #3 rst = 1'b0;

        // Idle with no start.
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) idle_bad++;
        end
        chk("idle no start", idle_bad, 0);

        // Good sweep with stimulus stepping checked edge by edge.
        mode0 = 0;
        start_sweep0();
        chk("step busy", busy0, 1);
        for (int j = 0; j < 16; j++) begin
            if (j > 0) tick();
            chk($sformatf("step abc edge %0d", j), {a0, b0, c0}, j / 2);
            if (j == 15) chk("step done before 16", done0, 0);
        end
        tick();
        check_result0("good", 8'hA8, 1'b1, 3'd0);
        chk("good abc hold", {a0, b0, c0}, 7);
        repeat (3) tick();
        chk("done holds", done0, 1);
        chk("table holds", tbl0, 8'hA8);

        // Table-driven sweeps over several stage behaviours.
        for (int i = 0; i < 6; i++) begin
            mode0 = vecs[i].mode;
            start_sweep0();
            chk($sformatf("vec%0d restart done low", i), done0, 0);
            chk($sformatf("vec%0d restart table clr", i), tbl0, 0);
            repeat (15) tick();
            chk($sformatf("vec%0d not done at 15", i), done0, 0);
            tick();
            check_result0($sformatf("vec%0d", i), vecs[i].tbl, vecs[i].pas, vecs[i].ff);
        end

        // Ignored start mid-sweep, then restart from DONE.
        mode0 = 0;
        start_sweep0();
        repeat (4) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (10) tick();
        chk("ignore start busy", busy0, 1);
        chk("ignore start done", done0, 0);
        tick();
        check_result0("ignore start", 8'hA8, 1'b1, 3'd0);
        start_sweep0();
        chk("restart done", done0, 0);
        chk("restart busy", busy0, 1);
        chk("restart table", tbl0, 0);
        chk("restart abc", {a0, b0, c0}, 0);
        repeat (16) tick();
        check_result0("second sweep", 8'hA8, 1'b1, 3'd0);

        // Asynchronous reset mid-sweep, no clock edge involved.
        mode0 = 1;
        start_sweep0();
        repeat (7) tick();
        chk("pre-reset busy", busy0, 1);
        chk("pre-reset partial table", tbl0, 8'h04);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async reset");
        rst = 1'b0;
        mode0 = 0;
        tick();
        chk("post-reset idle", busy0, 0);
        start_sweep0();
        repeat (16) tick();
        check_result0("after reset", 8'hA8, 1'b1, 3'd0);

        // HOLD_CYCLES=1 instance with a registered stage.
        mode1 = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        chk("h1 not done at 7", done1, 0);
        tick();
        chk("h1 done", done1, 1);
        chk("h1 table", tbl1, 8'hA8);
        chk("h1 pass", pass1, 1);
        chk("h1 first_fail", ff1, 0);

        mode1 = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        chk("h1 tie0 done", done1, 1);
        chk("h1 tie0 table", tbl1, 8'h00);
        chk("h1 tie0 pass", pass1, 0);
        chk("h1 tie0 first_fail", ff1, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
